// File: rtl/rs_err_correct_pp.sv
// Reed-Solomon error-correction stage.
// Upstream decoding hands over one error table (locations and XOR patterns) per
// block into a two-bank ping-pong store. As symbols of a block stream through,
// each symbol is XOR-corrected against the oldest loaded table. The result
// appears on the outputs one cycle later, and a per-block corrected count is
// reported together with the last symbol.
module rs_err_correct_pp #(
  parameter int SYM_BW = 8,
  parameter int N_NUM  = 255,
  parameter int T_NUM  = 8,
  localparam int ENW   = $clog2(T_NUM + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tbl_load,
  input  logic [ENW-1:0]          tbl_err_num,
  input  logic                    tbl_fail,
  input  logic [SYM_BW*T_NUM-1:0] err_loc,
  input  logic [SYM_BW*T_NUM-1:0] err_val,
  output logic                    tbl_ready,
  input  logic                    in_valid,
  input  logic [SYM_BW-1:0]       symb_cnt,
  input  logic [SYM_BW-1:0]       symb_in,
  output logic                    out_valid,
  output logic [SYM_BW-1:0]       out_cnt,
  output logic [SYM_BW-1:0]       out_data,
  output logic                    out_eob,
  output logic                    out_fail,
  output logic                    blk_done,
  output logic [ENW-1:0]          blk_corr,
  output logic                    tbl_ovf
);

  localparam logic [SYM_BW-1:0] N_SYM   = SYM_BW'(N_NUM);
  localparam logic [SYM_BW-1:0] ONE_SYM = SYM_BW'(1);

  // Table banks: control flags are reset, table contents are plain storage
  logic [1:0]        bank_vld;
  logic              old_bank;
  logic [ENW-1:0]    bank_num  [2];
  logic              bank_fail [2];
  logic [SYM_BW-1:0] bank_loc  [2][T_NUM];
  logic [SYM_BW-1:0] bank_val  [2][T_NUM];

  // Block tracking
  logic              blk_open;
  logic              act_use;
  logic              act_bank;
  logic [ENW-1:0]    corr_cnt;
  logic              ovf_r;

  // Output stage registers
  logic              vld_p1;
  logic [SYM_BW-1:0] cnt_p1;
  logic [SYM_BW-1:0] data_p1;
  logic              eob_p1;
  logic              fail_p1;
  logic              done_p1;
  logic [ENW-1:0]    corr_p1;

  // Combinational decode
  logic              accept;
  logic              is_first;
  logic              is_last;
  logic              blk_live;
  logic [1:0]        cand;
  logic              sel_any;
  logic              pick;
  logic              cur_use;
  logic              cur_bank;
  logic              hit;
  logic [SYM_BW-1:0] hit_val;
  logic              hit_eff;
  logic [ENW-1:0]    corr_next;
  logic              release_en;
  logic              load_en;
  logic              load_bank;
  logic              other_kept;

  assign tbl_ready = rst_n & ~(&bank_vld);
  assign load_en   = tbl_load & tbl_ready;
  assign load_bank = bank_vld[0];

  // Decode the arriving symbol and choose which bank (if any) corrects it
  always_comb begin
    accept    = in_valid && (symb_cnt != '0) && (symb_cnt <= N_SYM);
    is_first  = (symb_cnt == ONE_SYM);
    is_last   = (symb_cnt == N_SYM);
    blk_live  = is_first || blk_open;
    // The bank of a block being aborted cannot be re-selected for the new one
    cand[0]   = bank_vld[0] & ~(blk_open & act_use & (act_bank == 1'b0));
    cand[1]   = bank_vld[1] & ~(blk_open & act_use & (act_bank == 1'b1));
    sel_any   = |cand;
    pick      = (cand == 2'b11) ? old_bank : cand[1];
    cur_use   = is_first ? sel_any : (blk_open & act_use);
    cur_bank  = is_first ? pick : act_bank;
    release_en = accept && blk_open && act_use && (is_first || is_last);
    other_kept = bank_vld[~load_bank] && !(release_en && (act_bank == ~load_bank));
  end

  // Table lookup: scan high to low so the lowest matching entry wins
  always_comb begin
    hit     = 1'b0;
    hit_val = '0;
    for (int i = T_NUM - 1; i >= 0; i--) begin
      if ((ENW'(i) < bank_num[cur_bank]) && (bank_loc[cur_bank][i] == symb_cnt)) begin
        hit     = 1'b1;
        hit_val = bank_val[cur_bank][i];
      end
    end
    hit_eff   = cur_use && !bank_fail[cur_bank] && hit;
    corr_next = (is_first ? '0 : corr_cnt) + ENW'(hit_eff);
  end

  // Table storage: written into the free bank on an accepted load
  always_ff @(posedge clk) begin
    if (load_en) begin
      bank_num[load_bank]  <= tbl_err_num;
      bank_fail[load_bank] <= tbl_fail;
      for (int i = 0; i < T_NUM; i++) begin
        bank_loc[load_bank][i] <= err_loc[i*SYM_BW +: SYM_BW];
        bank_val[load_bank][i] <= err_val[i*SYM_BW +: SYM_BW];
      end
    end
  end

  // Bank bookkeeping, block tracking and the registered output stage (p1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_vld <= '0;
      old_bank <= 1'b0;
      ovf_r    <= 1'b0;
      blk_open <= 1'b0;
      act_use  <= 1'b0;
      act_bank <= 1'b0;
      corr_cnt <= '0;
      vld_p1   <= 1'b0;
      cnt_p1   <= '0;
      data_p1  <= '0;
      eob_p1   <= 1'b0;
      fail_p1  <= 1'b0;
      done_p1  <= 1'b0;
      corr_p1  <= '0;
    end else begin
      if (release_en) begin
        bank_vld[act_bank] <= 1'b0;
      end
      if (load_en) begin
        bank_vld[load_bank] <= 1'b1;
        old_bank            <= other_kept ? ~load_bank : load_bank;
      end
      if (tbl_load && !tbl_ready) begin
        ovf_r <= 1'b1;
      end
      vld_p1  <= accept;
      done_p1 <= accept && is_last && blk_live;
      if (accept) begin
        cnt_p1  <= symb_cnt;
        data_p1 <= symb_in ^ (hit_eff ? hit_val : '0);
        eob_p1  <= is_last;
        fail_p1 <= ~cur_use | bank_fail[cur_bank];
        if (is_last && blk_live) begin
          blk_open <= 1'b0;
          act_use  <= 1'b0;
          corr_cnt <= '0;
          corr_p1  <= corr_next;
        end else if (is_first) begin
          blk_open <= 1'b1;
          act_use  <= sel_any;
          act_bank <= pick;
          corr_cnt <= corr_next;
        end else if (blk_open) begin
          corr_cnt <= corr_next;
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_cnt   = cnt_p1;
  assign out_data  = data_p1;
  assign out_eob   = eob_p1;
  assign out_fail  = fail_p1;
  assign blk_done  = done_p1;
  assign blk_corr  = corr_p1;
  assign tbl_ovf   = ovf_r;

endmodule
